// File: rtl/parking_pkg.sv
// Shared types and constants for the parking rush-hour timer block.
// Pure declarations: no latency and no backpressure.
package parking_pkg;

    localparam int HOUR_W           = 4;
    localparam int DEF_CNT_1S       = 50_000_000;
    localparam int DEF_CNT_HOUR     = 3600;
    localparam int DEF_HOURS_PER_DAY = 8;

    typedef enum logic [0:0] {
        WAIT_FULL = 1'b0,
        RUSH      = 1'b1
    } occ_state_e;

endpackage

// File: rtl/parking_rush_timer_if.sv
// Groups the day-control/occupancy inputs and the timing/rush outputs of the block.
// Wires only: no latency and no backpressure.
interface parking_rush_timer_if;
    import parking_pkg::*;

    logic              work_day_increment;
    logic              slot_empty;
    logic              slot_full;
    logic [HOUR_W-1:0] work_hour;
    logic              expired_one_second;
    logic              expired_one_hour;
    logic              work_day_expired;
    logic              rush_start_valid;
    logic              rush_end_valid;

    modport master (
        output work_day_increment, slot_empty, slot_full,
        input  work_hour, expired_one_second, expired_one_hour,
               work_day_expired, rush_start_valid, rush_end_valid
    );

    modport slave (
        input  work_day_increment, slot_empty, slot_full,
        output work_hour, expired_one_second, expired_one_hour,
               work_day_expired, rush_start_valid, rush_end_valid
    );

endinterface

// File: rtl/parking_rush_timer_hour_timer.sv
// Prescaler -> seconds -> work-hour counters; expiry pulses decode registered state.
// Pulses are coincident with the counter wrap edge; free-running, no backpressure.
module hour_timer
    import parking_pkg::*;
#(
    parameter int CNT_1S        = DEF_CNT_1S,
    parameter int CNT_HOUR      = DEF_CNT_HOUR,
    parameter int HOURS_PER_DAY = DEF_HOURS_PER_DAY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    output logic [HOUR_W-1:0] work_hour_o,
    output logic              expired_one_second_o,
    output logic              expired_one_hour_o,
    output logic              work_day_expired_o
);

    localparam int PRE_W = (CNT_1S   > 1) ? $clog2(CNT_1S)   : 1;
    localparam int SEC_W = (CNT_HOUR > 1) ? $clog2(CNT_HOUR) : 1;

    logic [PRE_W-1:0]  pre_q,  pre_d;
    logic [SEC_W-1:0]  sec_q,  sec_d;
    logic [HOUR_W-1:0] hour_q, hour_d;

    logic sec_last, hour_last;

    assign expired_one_second_o = (pre_q == PRE_W'(CNT_1S - 1));
    assign sec_last             = (sec_q == SEC_W'(CNT_HOUR - 1));
    assign hour_last            = (hour_q == HOUR_W'(HOURS_PER_DAY - 1));
    assign expired_one_hour_o   = expired_one_second_o && sec_last;
    assign work_day_expired_o   = expired_one_hour_o && hour_last;
    assign work_hour_o          = hour_q;

    always_comb begin
        pre_d  = expired_one_second_o ? '0 : pre_q + PRE_W'(1);
        sec_d  = sec_q;
        hour_d = hour_q;
        if (expired_one_second_o) begin
            sec_d = sec_last ? '0 : sec_q + SEC_W'(1);
        end
        if (expired_one_hour_o) begin
            hour_d = hour_last ? '0 : hour_q + HOUR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || clr_i) begin
            pre_q  <= '0;
            sec_q  <= '0;
            hour_q <= '0;
        end else begin
            pre_q  <= pre_d;
            sec_q  <= sec_d;
            hour_q <= hour_d;
        end
    end

endmodule

// File: rtl/parking_rush_timer.sv
// Time base plus occupancy FSM emitting one-cycle rush start/end pulses.
// Rush pulses registered (one cycle after the slot level); no backpressure.
module parking_rush_timer
    import parking_pkg::*;
#(
    parameter int CNT_1S        = DEF_CNT_1S,
    parameter int CNT_HOUR      = DEF_CNT_HOUR,
    parameter int HOURS_PER_DAY = DEF_HOURS_PER_DAY
) (
    input  logic                 clk,
    input  logic                 reset,
    parking_rush_timer_if.slave  bus
);

    occ_state_e state_q;
    logic       rush_start_q;
    logic       rush_end_q;

    hour_timer #(
        .CNT_1S        (CNT_1S),
        .CNT_HOUR      (CNT_HOUR),
        .HOURS_PER_DAY (HOURS_PER_DAY)
    ) u_hour_timer (
        .clk                  (clk),
        .reset                (reset),
        .clr_i                (bus.work_day_increment),
        .work_hour_o          (bus.work_hour),
        .expired_one_second_o (bus.expired_one_second),
        .expired_one_hour_o   (bus.expired_one_hour),
        .work_day_expired_o   (bus.work_day_expired)
    );

    // Each state listens to one input only, so full&empty together resolve by state.
    always_ff @(posedge clk) begin
        if (!reset || bus.work_day_increment) begin
            state_q      <= WAIT_FULL;
            rush_start_q <= 1'b0;
            rush_end_q   <= 1'b0;
        end else begin
            rush_start_q <= 1'b0;
            rush_end_q   <= 1'b0;
            case (state_q)
                WAIT_FULL: if (bus.slot_full) begin
                    state_q      <= RUSH;
                    rush_start_q <= 1'b1;
                end
                RUSH: if (bus.slot_empty) begin
                    state_q    <= WAIT_FULL;
                    rush_end_q <= 1'b1;
                end
                default: state_q <= WAIT_FULL;
            endcase
        end
    end

    assign bus.rush_start_valid = rush_start_q;
    assign bus.rush_end_valid   = rush_end_q;

endmodule

// File: tb/tb_parking_rush_timer.sv
// Directed bench for parking_rush_timer with CNT_1S=5, CNT_HOUR=5, HOURS_PER_DAY=8.
module tb_parking_rush_timer;
    import parking_pkg::*;

    localparam int C1S = 5;
    localparam int CH  = 5;
    localparam int HPD = 8;
    localparam int HOUR_CYC = C1S * CH;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    parking_rush_timer_if bus ();

    parking_rush_timer #(
        .CNT_1S        (C1S),
        .CNT_HOUR      (CH),
        .HOURS_PER_DAY (HPD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_rush(input string tag, input logic s, input logic e);
        chk({tag, "_start"}, 32'(bus.rush_start_valid), 32'(s));
        chk({tag, "_end"},   32'(bus.rush_end_valid),   32'(e));
    endtask

    initial begin
        bus.work_day_increment = 1'b0;
        bus.slot_empty         = 1'b0;
        bus.slot_full          = 1'b1;   // must be ignored while in reset

        // Reset held low for 25 cycles: everything quiet.
        for (int i = 0; i < 25; i++) begin
            tick();
            chk("rst_hour", 32'(bus.work_hour), 32'd0);
            chk("rst_sec",  32'(bus.expired_one_second), 32'd0);
            chk("rst_hr",   32'(bus.expired_one_hour), 32'd0);
            chk("rst_day",  32'(bus.work_day_expired), 32'd0);
            chk_rush("rst", 1'b0, 1'b0);
        end
        chk("rst_state", 32'(dut.state_q), 32'(WAIT_FULL));
        bus.slot_full = 1'b0;
        reset = 1'b1;

        // Cycle c counts from reset release; a full 8-hour day is 200 cycles.
        for (int c = 0; c <= HPD * HOUR_CYC; c++) begin
            chk("tb_sec",  32'(bus.expired_one_second), 32'((c % C1S) == C1S - 1));
            chk("tb_hr",   32'(bus.expired_one_hour),   32'((c % HOUR_CYC) == HOUR_CYC - 1));
            chk("tb_hour", 32'(bus.work_hour),          32'((c / HOUR_CYC) % HPD));
            chk("tb_day",  32'(bus.work_day_expired),   32'(c == HPD * HOUR_CYC - 1));
            if (c < HPD * HOUR_CYC) tick();
        end

        // Empty toggling with no full never starts a rush.
        for (int i = 0; i < 4; i++) begin
            bus.slot_empty = ~i[0];
            tick();
            chk_rush("empty_only", 1'b0, 1'b0);
        end
        bus.slot_empty = 1'b0;
        chk("empty_state", 32'(dut.state_q), 32'(WAIT_FULL));

        // Full -> single start pulse one cycle later; re-toggling full is ignored.
        bus.slot_full = 1'b1;
        tick();  chk_rush("start", 1'b1, 1'b0);
        tick();  chk_rush("start_hold", 1'b0, 1'b0);
        bus.slot_full = 1'b0; tick(); chk_rush("refull0", 1'b0, 1'b0);
        bus.slot_full = 1'b1; tick(); chk_rush("refull1", 1'b0, 1'b0);
        bus.slot_full = 1'b0;
        bus.slot_empty = 1'b1;
        tick();  chk_rush("end", 1'b0, 1'b1);
        tick();  chk_rush("end_hold", 1'b0, 1'b0);
        chk("end_state", 32'(dut.state_q), 32'(WAIT_FULL));

        // Simultaneous full & empty: state decides which one counts.
        bus.slot_full = 1'b1;
        tick();  chk_rush("both_wait", 1'b1, 1'b0);
        tick();  chk_rush("both_rush", 1'b0, 1'b1);
        tick();  chk_rush("both_again", 1'b1, 1'b0);
        bus.slot_full = 1'b0;
        bus.slot_empty = 1'b0;

        // Mid-rush work_day_increment: quiet return to WAIT_FULL, time base restarts.
        tick(7);
        chk("pre_wdi_state", 32'(dut.state_q), 32'(RUSH));
        bus.work_day_increment = 1'b1;
        tick();
        bus.work_day_increment = 1'b0;
        chk_rush("wdi", 1'b0, 1'b0);
        chk("wdi_hour",  32'(bus.work_hour), 32'd0);
        chk("wdi_state", 32'(dut.state_q), 32'(WAIT_FULL));
        chk("wdi_sec0",  32'(bus.expired_one_second), 32'd0);
        bus.slot_empty = 1'b1;
        tick(3); chk_rush("wdi_noend", 1'b0, 1'b0);
        tick();  chk("wdi_sec4", 32'(bus.expired_one_second), 32'd1);
        bus.slot_empty = 1'b0;
        bus.slot_full = 1'b1;
        tick();  chk_rush("wdi_restart", 1'b1, 1'b0);
        bus.slot_full = 1'b0;

        // Reset while in RUSH at work_hour 3.
        bus.work_day_increment = 1'b1;
        tick();
        bus.work_day_increment = 1'b0;
        bus.slot_full = 1'b1;
        tick();
        bus.slot_full = 1'b0;
        tick(3 * HOUR_CYC - 1);
        chk("pre_rst_hour",  32'(bus.work_hour), 32'd3);
        chk("pre_rst_state", 32'(dut.state_q), 32'(RUSH));
        bus.slot_empty = 1'b1;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("mrst_hour",  32'(bus.work_hour), 32'd0);
        chk("mrst_state", 32'(dut.state_q), 32'(WAIT_FULL));
        chk("mrst_sec",   32'(bus.expired_one_second), 32'd0);
        chk("mrst_hr",    32'(bus.expired_one_hour), 32'd0);
        chk("mrst_day",   32'(bus.work_day_expired), 32'd0);
        chk_rush("mrst", 1'b0, 1'b0);
        tick();
        chk_rush("mrst_after", 1'b0, 1'b0);
        bus.slot_empty = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
